// File: rtl/conv_ser_pkg.sv
// conv_ser_pkg
// Shared definitions for the convolution output serializer:
//   - conv_ser_state_t : FSM state encoding (IDLE, SEND, DONE)
//   - FP16_SIGN_BIT    : bit position of the FP16 sign flag
//   - conv_ser_idx_w() : width of the word index, never less than 1 bit
package conv_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } conv_ser_state_t;

  localparam int FP16_SIGN_BIT = 15;

  // A single-word stream still needs a 1-bit index port.
  function automatic int conv_ser_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_output_serializer.sv
// conv_output_serializer
// Captures the flat FP16 result vector of a convolution layer on a start
// request and streams it out one word per valid/ready transfer, in
// ascending word index order.
//
// Ports:
//   clk        in   clock, all state changes on posedge
//   reset      in   synchronous active-high reset
//   start      in   one-cycle request to capture data_in and stream it
//   data_in    in   N*DATA_WIDTH flat vector, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy       out  high while streaming and during the done cycle
//   out_data   out  current word (0 outside SEND)
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts the current word
//   out_last   out  current word is index N-1
//   out_index  out  index of the current word
//   done       out  one-cycle pulse after the final transfer
//
// Build option:
//   CONV_SER_RELU_EN  when defined, words with the sign bit set are
//                     emitted as 0x0000 (negatives, -0, negative NaN).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// SEND  | presenting word[index]; advances on each accepted transfer
// DONE  | one-cycle done pulse, then back to IDLE unconditionally
module conv_output_serializer
  import conv_ser_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int output_channel = 120,
  parameter int OH             = 1,
  parameter int OW             = 1,
  localparam int N             = output_channel * OH * OW,
  localparam int IDX_W         = conv_ser_idx_w(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N*DATA_WIDTH-1:0] data_in,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [IDX_W-1:0]        out_index,
  output logic                    done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  conv_ser_state_t state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             capture;

  // Shadow copy of the layer result; deliberately not reset, it is only
  // ever read after a capture.
  logic [DATA_WIDTH-1:0] shadow [N];
  logic [DATA_WIDTH-1:0] cur_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && capture) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          index_d = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        index_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        index_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cur_word = shadow[index_q];

  always_comb begin
    out_valid = (state_q == ST_SEND);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    out_last  = (state_q == ST_SEND) && (index_q == LAST_IDX);
    out_index = index_q;
    out_data  = '0;
    if (state_q == ST_SEND) begin
`ifdef CONV_SER_RELU_EN
      // Clamp on the output path only; the shadow keeps the raw word.
      out_data = cur_word[FP16_SIGN_BIT] ? '0 : cur_word;
`else
      out_data = cur_word;
`endif
    end
  end

endmodule

// File: tb/tb_conv_output_serializer.sv
module tb_conv_output_serializer;

  localparam int DW = 16;
  localparam int OC = 120;
  localparam int OH = 1;
  localparam int OW = 1;
  localparam int N  = OC * OH * OW;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N*DW-1:0] data_in;
  logic          busy;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [IW-1:0] out_index;
  logic          done;

  logic [DW-1:0] words [N];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  conv_output_serializer #(
    .DATA_WIDTH(DW), .output_channel(OC), .OH(OH), .OW(OW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_index(out_index),
    .done(done)
  );

  // Expected emitted word from the captured word.
  function automatic logic [15:0] ref_out(input logic [15:0] w);
`ifdef CONV_SER_RELU_EN
    return w[15] ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_index"}, 32'(out_index), 32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
  endtask

  task automatic pack_words();
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = words[i];
  endtask

  // pat: 0 = ready always high, 1 = 1,0,0,1 repeating, 2 = random.
  // inject_at: word index at which data_in is trashed and start re-pulsed.
  // reset_at: word index at which reset is asserted (stream abandoned).
  task automatic run_stream(input int pat, input int inject_at, input int reset_at);
    int  idx, k, iter;
    bit  injected;
    logic r;
    idx = 0; k = 0; iter = 0; injected = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'($urandom % 2);
    @(negedge clk);
    start = 1'b0;
    while (idx < N && iter < 4*N + 20) begin
      check("s_valid", 32'(out_valid), 32'd1);
      check("s_busy",  32'(busy),      32'd1);
      check("s_index", 32'(out_index), 32'(idx));
      check("s_data",  32'(out_data),  32'(ref_out(words[idx])));
      check("s_last",  32'(out_last),  32'(idx == N-1));
      check("s_done",  32'(done),      32'd0);
      start = 1'b0;
      if (idx == inject_at && !injected) begin
        injected = 1;
        data_in  = '1;
        start    = 1'b1;
      end
      if (idx == reset_at) begin
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("midrst");
        repeat (3) begin
          @(negedge clk);
          check("midrst_nodone",  32'(done),      32'd0);
          check("midrst_novalid", 32'(out_valid), 32'd0);
        end
        return;
      end
      case (pat)
        0:       r = 1'b1;
        1:       r = (k % 4 == 0) || (k % 4 == 3);
        default: r = 1'($urandom % 2);
      endcase
      out_ready = r;
      k++;
      iter++;
      @(negedge clk);
      start = 1'b0;
      if (r) idx++;
    end
    check("stream_count", 32'(idx), 32'(N));
    if (pat == 0) check("stream_cycles", 32'(iter), 32'(N));
    check("end_done",  32'(done),      32'd1);
    check("end_busy",  32'(busy),      32'd1);
    check("end_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("post_done",  32'(done),      32'd0);
    check("post_busy",  32'(busy),      32'd0);
    check("post_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("post2_done",  32'(done),      32'd0);
    check("post2_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    data_in = '0;

    // Reset and idle behaviour
    repeat (2) @(negedge clk);
    check_idle("rst");
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_busy",  32'(busy),      32'd0);
    end

    // Full stream, ready held high
    for (int i = 0; i < N; i++) words[i] = 16'(16'h3C00 + i);
    pack_words();
    run_stream(0, -1, -1);

    // Backpressure 1,0,0,1 with random words
    for (int i = 0; i < N; i++) words[i] = 16'($urandom);
    pack_words();
    run_stream(1, -1, -1);

    // Capture isolation and ignored start at index 50
    for (int i = 0; i < N; i++) words[i] = 16'(16'h3C00 + i);
    pack_words();
    run_stream(0, 50, -1);

    // Reset mid-stream at index 60, then a clean restart from index 0
    for (int i = 0; i < N; i++) words[i] = 16'($urandom);
    pack_words();
    run_stream(2, -1, 60);
    for (int i = 0; i < N; i++) words[i] = 16'($urandom);
    pack_words();
    run_stream(2, -1, -1);

    // Same-edge reset and start: reset wins
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check_idle("rst_start");
    @(negedge clk);
    check("rst_start_valid", 32'(out_valid), 32'd0);

    // Sign handling: negative and negative-zero words
    for (int i = 0; i < N; i++) words[i] = 16'($urandom);
    words[5] = 16'hC000;
    words[6] = 16'h8000;
    pack_words();
    run_stream(2, -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
